// File: rtl/fetch_queue_unit_if.sv
`default_nettype none
// fetch_queue_unit_if: memory read port, redirect, and decode-side queue head bundle.
// Rev 1.0
interface fetch_queue_unit_if #(
  parameter int DEPTH = 4
);
  localparam int c_CNT_W = $clog2(DEPTH) + 1;

  logic               mem_ren;
  logic [31:0]        mem_raddr;
  logic [31:0]        mem_rdata;
  logic               redirect_valid;
  logic [31:0]        redirect_pc;
  logic               instr_valid;
  logic [31:0]        instr;
  logic [31:0]        instr_pc;
  logic               instr_ready;
  logic [c_CNT_W-1:0] queue_count;

  modport master (
    output mem_ren, mem_raddr, instr_valid, instr, instr_pc, queue_count,
    input  mem_rdata, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  mem_ren, mem_raddr, instr_valid, instr, instr_pc, queue_count,
    output mem_rdata, redirect_valid, redirect_pc, instr_ready
  );
endinterface
`default_nettype wire

// File: rtl/fetch_queue_unit.sv
`default_nettype none
// fetch_queue_unit: sequential word fetch with a PC-tagged prefetch queue and redirect flush.
// Rev 1.0
module fetch_queue_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  wire logic           clk,
  input  wire logic           rst,
  fetch_queue_unit_if.master  bus
);
  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W:0] c_DEPTH_OCC = (c_CNT_W + 1)'(DEPTH);
  localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

  logic [31:0]        r_fetch_pc;
  logic               r_inflight;
  logic [31:0]        r_inflight_pc;
  logic [31:0]        r_q_instr [DEPTH];
  logic [31:0]        r_q_pc    [DEPTH];
  logic [c_PTR_W-1:0] r_head;
  logic [c_PTR_W-1:0] r_tail;
  logic [c_CNT_W-1:0] r_count;

  logic [c_CNT_W:0]   w_occ;
  logic               w_issue;
  logic               w_push;
  logic               w_pop;
  logic               w_nonempty;

  // Queued entries plus the outstanding read must fit, so a return always finds space.
  assign w_occ      = {1'b0, r_count} + {{c_CNT_W{1'b0}}, r_inflight};
  assign w_issue    = !rst && !bus.redirect_valid && (w_occ < c_DEPTH_OCC);
  assign w_push     = !rst && !bus.redirect_valid && r_inflight;
  assign w_nonempty = (r_count != '0);
  assign w_pop      = !rst && !bus.redirect_valid && w_nonempty && bus.instr_ready;

  assign bus.mem_ren     = w_issue;
  assign bus.mem_raddr   = r_fetch_pc;
  assign bus.instr_valid = !rst && w_nonempty;
  assign bus.instr       = r_q_instr[r_head];
  assign bus.instr_pc    = r_q_pc[r_head];
  assign bus.queue_count = rst ? '0 : r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_inflight <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else if (bus.redirect_valid) begin
      r_fetch_pc <= bus.redirect_pc;
      r_inflight <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_fetch_pc;
        r_fetch_pc    <= r_fetch_pc + 32'd1;
      end
      if (w_push) begin
        r_tail <= r_tail + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + c_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset; the count alone decides what is visible.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_instr[r_tail] <= bus.mem_rdata;
      r_q_pc[r_tail]    <= r_inflight_pc;
    end
  end

`ifndef SYNTHESIS
  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
    !(w_push && (r_count == c_DEPTH_CNT)));
`endif

endmodule
`default_nettype wire

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
Instruction fetch front end that feeds the decode/issue stage of the pipelined core. It owns the fetch PC and issues sequential word reads on the instruction port of main memory. Returned words, tagged with their PC, are buffered in a small prefetch queue so that decode stalls do not lose fetched data. A redirect input from the branch/jump logic flushes the queue, squashes the in-flight read and restarts fetch at a new PC.

Parameters:
DEPTH, 4, prefetch queue entries; power of two, minimum 2
RESET_PC, 32'h0, first fetch address after reset

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  reset: one clock; reset is synchronous and active-high
mem_ren  output  1  read request to the instruction memory port this cycle
mem_raddr  output  32  word address of the request (the fetch PC)
mem_rdata  input  32  read data; valid the cycle after the matching request
redirect_valid  input  1  flush the queue and restart fetch at redirect_pc
redirect_pc  input  32  new fetch address
instr_valid  output  1  queue head holds a valid instruction
instr  output  32  instruction word at the queue head
instr_pc  output  32  PC of the instruction at the queue head
instr_ready  input  1  decode accepts the head this cycle
queue_count  output  $clog2(DEPTH)+1  entries currently held

Behaviour:
- State: fetch_pc (32), inflight (1), inflight_pc (32), queue of DEPTH {instr, pc} entries with head/tail pointers, and count.
- Reset (rst=1 at posedge): fetch_pc=RESET_PC, inflight=0, count=0, pointers=0. While rst=1: mem_ren=0, instr_valid=0, queue_count=0. instr and instr_pc are don't-care when instr_valid=0.
- Addressing is by word: sequential PC = PC+1, with modulo-2^32 wrap (32'hFFFFFFFF -> 32'h0).
- Issue rule (combinational): mem_ren = !rst && !redirect_valid && (count + inflight < DEPTH). mem_raddr = fetch_pc at all times.
- Issue update: when mem_ren=1, set inflight<=1, inflight_pc<=fetch_pc and fetch_pc<=fetch_pc+1. Otherwise set inflight<=0.
- Return: when inflight=1 and redirect_valid=0, push {mem_rdata, inflight_pc} at the tail. The space rule guarantees the queue is never full at push time; push-when-full is unreachable and is checked by an assertion.
- Output: instr_valid = (count!=0), taken from the head combinationally. Pop when instr_valid && instr_ready.
- Simultaneous push and pop: count stays the same. A push into an empty queue becomes visible the following cycle; there is no bypass.
- Redirect (redirect_valid=1 at posedge) has the highest priority after reset:
  - count<=0 and pointers are cleared.
  - The in-flight return in the same cycle is discarded and inflight<=0.
  - Any pop that cycle is ignored; decode must treat the redirect cycle's instruction as squashed.
  - fetch_pc<=redirect_pc and no request is issued that cycle.
- Latency:
  - First request is in the first cycle after rst falls. Data is pushed one cycle later, so instr_valid rises 2 cycles after the request.
  - Redirect-to-valid: the request for redirect_pc goes out in the cycle after redirect, and instr_valid (instr_pc=redirect_pc) rises 2 cycles after that.
- Throughput: 1 instruction per cycle with instr_ready held high.
- Back-pressure: with instr_ready low, fetch stops once count + inflight = DEPTH. This is the full state: queue_count=DEPTH and mem_ren=0.
- Reset mid-operation discards the queue and any in-flight read. No stale data appears after reset.

Test Plan:
- Reset release, RESET_PC=0, memory holds word k at address k, instr_ready=1 -> mem_ren high from cycle 0; instr_valid at cycle 2 with instr_pc 0,1,2,3... on consecutive cycles.
- instr_ready=0 for 10 cycles after streaming starts -> queue_count reaches 4, mem_ren=0; on release, PCs continue gaplessly with no duplicates.
- Redirect to 32'h100 while count=3 and a read is in flight -> next valid instr_pc=32'h100 exactly 3 cycles after redirect; the old queued PCs and the in-flight PC never appear.
- Redirect coinciding with a pop and a return in the same cycle -> queue_count=0 the next cycle; only PCs from 32'h100 onward are delivered.
- Redirect to 32'hFFFFFFFE, streaming -> instr_pc sequence FFFFFFFE, FFFFFFFF, 00000000.
- rst asserted for 1 cycle with count=2 -> instr_valid=0 next cycle; the stream restarts at RESET_PC with 2-cycle latency.
